// File: rtl/uart_pkg.sv
// Shared types and constants for the uart transmit path.
// Arbiter state encoding and the tx handshake timing.
package uart_pkg;

   localparam int BYTE_W = 8;

   // cycles to wait for tx_rdy to drop after a tx_start
   localparam int TX_BUSY_WAIT = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE,
      LOCKED
   } arb_state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr.
// Purely combinational; returns a one-hot and an index.
module uart_rr_pick
   import uart_pkg::*;
#(
   parameter int N = 2,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] j;

   // scan ptr, ptr+1, ... wrapping, keep the first hit
   always_comb begin
      valid  = 1'b0;
      onehot = '0;
      idx    = '0;
      j      = '0;
      for (int k = 0; k < N; k++) begin
         j = IW'((int'(ptr) + k) % N);
         if (!valid && req[j]) begin
            valid     = 1'b1;
            onehot[j] = 1'b1;
            idx       = j;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N sources.
// An owner keeps the transmitter until its last byte or a timeout.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N            = 2,
   parameter int IDLE_TIMEOUT = 1024,
   parameter int BUSY_WAIT    = TX_BUSY_WAIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        req,
   input  logic [BYTE_W*N-1:0] din,
   input  logic [N-1:0]        last,
   output logic [N-1:0]        ack,
   output logic [N-1:0]        grant,
   output logic                tx_start,
   output logic [BYTE_W-1:0]   tx_din,
   input  logic                tx_rdy,
   output logic                busy
);

   localparam int IW = idx_w(N);
   localparam int CW = $clog2(IDLE_TIMEOUT + 1);
   localparam int BW = $clog2(BUSY_WAIT + 1);

   localparam logic [CW-1:0] IT_LAST = CW'(IDLE_TIMEOUT - 1);
   localparam logic [BW-1:0] BW_LAST = BW'(BUSY_WAIT - 1);

   arb_state_t state, state_d;

   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     own_q, own_d;
   logic              lock_q, lock_d;
   logic [CW-1:0]     icnt_q, icnt_d;
   logic [BW-1:0]     bcnt_q, bcnt_d;
   logic [N-1:0]      ack_d, grant_d;
   logic              start_d;
   logic [BYTE_W-1:0] din_d;

   logic              pick_v;
   logic [N-1:0]      pick_oh;
   logic [IW-1:0]     pick_idx;

   logic [BYTE_W-1:0] din_a [N];

   function automatic logic [IW-1:0] wrap_inc(
      input logic [IW-1:0] i
   );
      return (int'(i) == N - 1) ? '0 : i + 1'b1;
   endfunction

   uart_rr_pick #(
      .N(N)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .valid  (pick_v),
      .onehot (pick_oh),
      .idx    (pick_idx)
   );

   // split the flat byte bus into per-requester lanes
   always_comb begin
      for (int k = 0; k < N; k++) begin
         din_a[k] = din[k*BYTE_W +: BYTE_W];
      end
   end

   // next state, next owner and next registered outputs
   always_comb begin
      state_d = state;
      ptr_d   = ptr_q;
      own_d   = own_q;
      lock_d  = lock_q;
      icnt_d  = icnt_q;
      bcnt_d  = bcnt_q;
      ack_d   = '0;
      start_d = 1'b0;
      grant_d = grant;
      din_d   = tx_din;
      unique case (state)
         IDLE: begin
            if (tx_rdy && pick_v) begin
               own_d   = pick_idx;
               din_d   = din_a[pick_idx];
               start_d = 1'b1;
               ack_d   = pick_oh;
               grant_d = pick_oh;
               lock_d  = ~last[pick_idx];
               bcnt_d  = '0;
               state_d = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!tx_rdy || bcnt_q == BW_LAST) begin
               state_d = WAIT_DONE;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (tx_rdy) begin
               if (lock_q) begin
                  icnt_d  = '0;
                  state_d = LOCKED;
               end else begin
                  ptr_d   = wrap_inc(own_q);
                  grant_d = '0;
                  state_d = IDLE;
               end
            end
         end
         LOCKED: begin
            if (req[own_q]) begin
               if (tx_rdy) begin
                  din_d   = din_a[own_q];
                  start_d = 1'b1;
                  ack_d   = grant;
                  lock_d  = ~last[own_q];
                  bcnt_d  = '0;
                  icnt_d  = '0;
                  state_d = WAIT_BUSY;
               end
            end else if (icnt_q == IT_LAST) begin
               ptr_d   = wrap_inc(own_q);
               grant_d = '0;
               lock_d  = 1'b0;
               icnt_d  = '0;
               state_d = IDLE;
            end else begin
               icnt_d = icnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state, arbitration context and all outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ptr_q    <= '0;
         own_q    <= '0;
         lock_q   <= 1'b0;
         icnt_q   <= '0;
         bcnt_q   <= '0;
         ack      <= '0;
         grant    <= '0;
         tx_start <= 1'b0;
         tx_din   <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         ptr_q    <= ptr_d;
         own_q    <= own_d;
         lock_q   <= lock_d;
         icnt_q   <= icnt_d;
         bcnt_q   <= bcnt_d;
         ack      <= ack_d;
         grant    <= grant_d;
         tx_start <= start_d;
         tx_din   <= din_d;
         busy     <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a uart_tx model
// and an expected-byte scoreboard, driven from one process.
module tb_uart_tx_arbiter;

   localparam int IT    = 20;
   localparam int BW    = 4;
   localparam int TXLEN = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req = '0;
   logic [15:0] din = '0;
   logic [1:0]  last = '0;
   logic        tx_rdy = 1'b1;
   logic [1:0]  ack;
   logic [1:0]  grant;
   logic        tx_start;
   logic [7:0]  tx_din;
   logic        busy;

   uart_tx_arbiter #(
      .N(2),
      .IDLE_TIMEOUT(IT),
      .BUSY_WAIT(BW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .din      (din),
      .last     (last),
      .ack      (ack),
      .grant    (grant),
      .tx_start (tx_start),
      .tx_din   (tx_din),
      .tx_rdy   (tx_rdy),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] b;
      logic       l;
   } rb_t;

   typedef struct packed {
      logic [7:0] b;
      logic [1:0] a;
   } ex_t;

   typedef struct {
      int              n0;
      logic [2:0][7:0] b0;
      logic [2:0]      l0;
      int              n1;
      logic [2:0][7:0] b1;
      logic [2:0]      l1;
      int              ne;
      logic [5:0][7:0] eb;
      logic [5:0][1:0] ea;
   } vec_t;

   rb_t  q0[$];
   rb_t  q1[$];
   ex_t  exq[$];
   vec_t vt[6];

   int checks = 0;
   int errors = 0;
   int cnt    = 0;
   bit pend   = 1'b0;
   bit stuck  = 1'b0;
   bit flow   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s", nm);
   endtask

   // one cycle: check outputs, step uart model, step requesters
   task automatic tick();
      ex_t e;
      @(negedge clk);
      if (tx_start) begin
         if (exq.size() == 0) begin
            fail($sformatf("sb_empty: got byte %0h, expected none",
                           tx_din));
         end else begin
            e = exq.pop_front();
            chk("tx_din", 32'(tx_din), 32'(e.b));
            chk("ack", 32'(ack), 32'(e.a));
            chk("grant", 32'(grant), 32'(e.a));
         end
      end else begin
         chk("ack_idle", 32'(ack), 32'd0);
      end
      if (flow) begin
         tx_rdy = 1'b0;
      end else if (pend) begin
         tx_rdy = 1'b0;
         cnt    = TXLEN;
         pend   = 1'b0;
      end else if (cnt > 0) begin
         cnt--;
         if (cnt == 0) tx_rdy = 1'b1;
      end else begin
         tx_rdy = 1'b1;
      end
      if (tx_start && !stuck) pend = 1'b1;
      if (ack[0] && q0.size() > 0) q0.delete(0);
      if (ack[1] && q1.size() > 0) q1.delete(0);
      req[0]    = (q0.size() > 0);
      din[7:0]  = (q0.size() > 0) ? q0[0].b : 8'h00;
      last[0]   = (q0.size() > 0) ? q0[0].l : 1'b0;
      req[1]    = (q1.size() > 0);
      din[15:8] = (q1.size() > 0) ? q1[0].b : 8'h00;
      last[1]   = (q1.size() > 0) ? q1[0].l : 1'b0;
   endtask

   task automatic push(input int r, input logic [7:0] b,
                       input logic l);
      rb_t x;
      x.b = b;
      x.l = l;
      if (r == 0) q0.push_back(x);
      else q1.push_back(x);
   endtask

   task automatic expect_b(input logic [7:0] b,
                           input logic [1:0] a);
      ex_t x;
      x.b = b;
      x.a = a;
      exq.push_back(x);
   endtask

   task automatic clear_all();
      q0.delete();
      q1.delete();
      exq.delete();
      pend   = 1'b0;
      cnt    = 0;
      stuck  = 1'b0;
      flow   = 1'b0;
      tx_rdy = 1'b1;
      req    = '0;
      din    = '0;
      last   = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_all();
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic run_until_done(input int maxc);
      int n;
      n = 0;
      while (!(exq.size() == 0 && q0.size() == 0 &&
               q1.size() == 0 && !busy && grant == 2'b00)) begin
         tick();
         n++;
         if (n > maxc) begin
            fail($sformatf("done_timeout: %0d bytes still expected",
                           exq.size()));
            break;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int lc;
      vt[0] = '{1, 24'h000041, 3'b001, 0, 24'h0, 3'b000,
                1, 48'h41, {10'b0, 2'b01}};
      vt[1] = '{0, 24'h0, 3'b000, 1, 24'h00007E, 3'b001,
                1, 48'h7E, {10'b0, 2'b10}};
      vt[2] = '{2, 24'h005555, 3'b011, 2, 24'h00AAAA, 3'b011,
                4, 48'h0000AA55AA55,
                {4'b0, 2'b10, 2'b01, 2'b10, 2'b01}};
      vt[3] = '{3, 24'h121110, 3'b100, 1, 24'h000020, 3'b001,
                4, 48'h000020121110,
                {4'b0, 2'b10, 2'b01, 2'b01, 2'b01}};
      vt[4] = '{1, 24'h000040, 3'b001, 2, 24'h003130, 3'b010,
                3, 48'h000000313040,
                {6'b0, 2'b10, 2'b10, 2'b01}};
      vt[5] = '{1, 24'h000001, 3'b001, 2, 24'h000302, 3'b011,
                3, 48'h000000030201,
                {6'b0, 2'b10, 2'b10, 2'b01}};

      #1 rst = 1'b0;
      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_start", 32'(tx_start), 32'd0);
      chk("rst_din", 32'(tx_din), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      push(0, 8'h41, 1'b1);
      expect_b(8'h41, 2'b01);
      tick();
      chk("lat_pre", 32'(tx_start), 32'd0);
      tick();
      chk("lat_start", 32'(tx_start), 32'd1);
      run_until_done(200);
      chk("single_grant", 32'(grant), 32'd0);

      push(0, 8'h61, 1'b1);
      push(1, 8'h62, 1'b1);
      expect_b(8'h62, 2'b10);
      expect_b(8'h61, 2'b01);
      run_until_done(200);

      for (int v = 0; v < 6; v++) begin
         do_reset();
         for (int k = 0; k < vt[v].n0; k++)
            push(0, vt[v].b0[k], vt[v].l0[k]);
         for (int k = 0; k < vt[v].n1; k++)
            push(1, vt[v].b1[k], vt[v].l1[k]);
         for (int k = 0; k < vt[v].ne; k++)
            expect_b(vt[v].eb[k], vt[v].ea[k]);
         run_until_done(400);
         chk($sformatf("vec%0d_grant", v), 32'(grant), 32'd0);
      end

      do_reset();
      push(0, 8'h70, 1'b0);
      push(1, 8'h80, 1'b1);
      expect_b(8'h70, 2'b01);
      expect_b(8'h80, 2'b10);
      n = 0;
      while (exq.size() != 1 && n < 50) begin tick(); n++; end
      n = 0;
      while (tx_rdy && n < 50) begin tick(); n++; end
      n = 0;
      while (!tx_rdy && n < 50) begin tick(); n++; end
      lc = 0;
      n  = 0;
      do begin
         tick();
         n++;
         if (grant == 2'b01) lc++;
      end while (grant == 2'b01 && n < 4 * IT);
      chk("lock_hold", 32'(lc), 32'(IT));
      run_until_done(200);

      do_reset();
      stuck = 1'b1;
      push(0, 8'h90, 1'b1);
      expect_b(8'h90, 2'b01);
      n = 0;
      while (exq.size() != 0 && n < 50) begin tick(); n++; end
      lc = 0;
      n  = 0;
      while (busy && n < 50) begin
         tick();
         n++;
         if (busy) lc++;
      end
      chk("busy_wait", 32'(lc), 32'(BW));
      stuck = 1'b0;
      run_until_done(200);

      do_reset();
      flow = 1'b1;
      tick();
      push(0, 8'hB5, 1'b1);
      expect_b(8'hB5, 2'b01);
      lc = 0;
      repeat (20) begin
         tick();
         if (tx_start || ack != 2'b00) lc++;
      end
      chk("rdy_low_hold", 32'(lc), 32'd0);
      chk("rdy_low_grant", 32'(grant), 32'd0);
      flow = 1'b0;
      run_until_done(200);

      do_reset();
      push(0, 8'hC0, 1'b1);
      expect_b(8'hC0, 2'b01);
      run_until_done(200);
      push(0, 8'hA0, 1'b0);
      push(0, 8'hA1, 1'b0);
      push(0, 8'hA2, 1'b1);
      expect_b(8'hA0, 2'b01);
      n = 0;
      while (exq.size() != 0 && n < 50) begin tick(); n++; end
      n = 0;
      while (tx_rdy && n < 50) begin tick(); n++; end
      tick();
      tick();
      #2 rst = 1'b0;
      #1;
      chk("mid_ack", 32'(ack), 32'd0);
      chk("mid_grant", 32'(grant), 32'd0);
      chk("mid_start", 32'(tx_start), 32'd0);
      chk("mid_din", 32'(tx_din), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      clear_all();
      tick();
      tick();
      rst = 1'b1;
      tick();
      push(1, 8'hD1, 1'b1);
      push(0, 8'hD0, 1'b1);
      expect_b(8'hD0, 2'b01);
      expect_b(8'hD1, 2'b10);
      run_until_done(200);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer between N byte sources, e.g. the uart_rx echo path and a status/message generator. Arbitration is round-robin with message locking: a requester keeps the transmitter until it flags the last byte of its message. The block sequences the uart_tx start/rdy handshake and sits between the requesters and uart_tx in the top level.

Parameters:
N, 2, number of requesters (N >= 1)
IDLE_TIMEOUT, 1024, cycles a locked owner may hold req low before its lock is dropped
BUSY_WAIT, 4, cycles to wait for tx_rdy to fall after tx_start before continuing anyway

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
req  input  N  per-requester byte valid; held until ack
din  input  8*N  per-requester byte; requester i uses din[8*i+7:8*i]
last  input  N  byte on din[i] is the last of its message
ack  output  N  one-cycle pulse: byte from requester i accepted
grant  output  N  one-hot current owner; 0 when no owner
tx_start  output  1  one-cycle start pulse to uart_tx
tx_din  output  8  byte to uart_tx; stable from tx_start until next issue
tx_rdy  input  1  uart_tx idle; falls the cycle after it samples tx_start
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous, active-low: state=IDLE, ptr=0, lock=0, idle_cnt=0. Outputs ack, grant, tx_start, tx_din and busy are all 0.
- All outputs are registered. tx_start and ack[i] assert in the same cycle.
- Issue latency: req[i] sampled high in IDLE with tx_rdy=1 -> tx_start and ack[i] high on the next cycle.
- IDLE: if tx_rdy=1 and req!=0, select i = first set req bit searching ptr, ptr+1, ... N-1, 0, ... (wraps).
  - Registers: tx_din<=din[i], tx_start<=1, ack[i]<=1, grant<=onehot(i), lock<=~last[i].
  - Next state WAIT_BUSY.
  - If tx_rdy=0, stay in IDLE and issue nothing.
- WAIT_BUSY: go to WAIT_DONE when tx_rdy=0, or after BUSY_WAIT cycles in this state.
- WAIT_DONE: wait for tx_rdy=1.
  - If lock=1: next state LOCKED, idle_cnt=0.
  - If lock=0: ptr<=(i+1) mod N, grant<=0, next state IDLE.
- LOCKED: only requester i is considered; req from any other requester is ignored.
  - tx_rdy=1 and req[i]=1: issue exactly as in IDLE for index i (lock<=~last[i]), next state WAIT_BUSY, idle_cnt<=0.
  - req[i]=0: idle_cnt increments. When idle_cnt reaches IDLE_TIMEOUT-1, set ptr<=(i+1) mod N, grant<=0, lock<=0, next state IDLE.
- Requester contract: hold req/din/last stable until ack. On the cycle after ack, drop req or present the next byte. No double accept is possible because the arbiter is in WAIT_BUSY that cycle.
- ptr changes only when a message ends: last byte accepted and sent, or lock timeout. After owner N-1 it wraps to 0.
- N=1: degenerates to a pass-through sequencer; ptr is always 0.
- Reset mid-transfer: the pending message is dropped. The requester must restart its message after reset.

Decomposition:
- Package uart_pkg holds:
  - arbiter state encoding: IDLE, WAIT_BUSY, WAIT_DONE, LOCKED
  - BYTE_W=8
  - the shared uart_tx handshake timing constant
- Sub-module uart_rr_pick (combinational): inputs req[N] and ptr; outputs valid and a one-hot/index selection. It is reusable for future rx fan-out.

Test Plan:
- Single byte: req=01, din[0]=8'h41, last=1, tx_rdy model -> tx_start one cycle after req; tx_din=8'h41, ack=01, grant=01. After tx_rdy returns: grant=0, ptr=1.
- Round-robin: req=11 constant, last=11, din=8'h55/8'hAA -> tx_din sequence 8'h55, 8'hAA, 8'h55, 8'hAA. ack alternates 01, 10.
- Message lock: req[0] sends 3 bytes 8'h10, 8'h11, 8'h12 with last only on 8'h12; req[1]=1 throughout -> all three req[0] bytes go out before 8'h20 from req[1].
- Lock timeout: req[0] sends one byte with last=0, then drops req for IDLE_TIMEOUT cycles -> grant returns to 0 at cycle IDLE_TIMEOUT. Pending req[1] is issued next.
- tx_rdy stuck high after tx_start -> leaves WAIT_BUSY after BUSY_WAIT=4 cycles. tx_rdy held low in IDLE -> no tx_start and no ack while req=01 is held.
- Async reset asserted in WAIT_DONE mid-message -> all outputs 0 immediately; after release, state is IDLE and ptr=0.
